// File: rtl/layer_stream_host.sv
// layer_stream_host: host-side buffering and handshake sequencer for one layer.
// The host loads an N-word input vector, pulses start, and the block streams
// the vector out on m_*, collects M results on s_*, then pulses done.
// Optional feature macro: ARGMAX_EN adds a running signed argmax over the
// results of each run; without it argmax_idx/argmax_val are tied to zero.
module layer_stream_host #(
  parameter int unsigned N  = 12,
  parameter int unsigned M  = 16,
  parameter int unsigned T  = 20,
  parameter int unsigned LN = $clog2(N),
  parameter int unsigned LM = $clog2(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [LN-1:0] wr_addr,
  input  logic [T-1:0]  wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [T-1:0]  m_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [T-1:0]  s_data,
  input  logic [LM-1:0] rd_addr,
  output logic [T-1:0]  rd_data,
  output logic [LM-1:0] argmax_idx,
  output logic [T-1:0]  argmax_val
);

  typedef enum logic [1:0] {IDLE, SEND, RECV, FIN} state_t;

  state_t        state, state_d;
  logic [T-1:0]  inbuf  [N];
  logic [T-1:0]  resbuf [M];
  logic [LN-1:0] send_cnt;
  logic [LM-1:0] recv_cnt;
  logic [LN-1:0] send_nxt_c;

  logic wr_acc_c;
  logic start_acc_c;
  logic send_xfer_c;
  logic send_last_c;
  logic recv_xfer_c;
  logic recv_last_c;

  assign send_nxt_c  = send_cnt + LN'(1);
  assign send_last_c = (send_cnt == LN'(N - 1));
  assign recv_last_c = (recv_cnt == LM'(M - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic and per-cycle handshake strobes
  always_comb begin
    state_d     = state;
    start_acc_c = 1'b0;
    send_xfer_c = 1'b0;
    recv_xfer_c = 1'b0;
    wr_acc_c    = 1'b0;
    if (!reset && state == IDLE && wr_en && (32'(wr_addr) < N)) wr_acc_c = 1'b1;
    case (state)
      IDLE: begin
        if (start) begin
          start_acc_c = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (m_valid && m_ready) begin
          send_xfer_c = 1'b1;
          if (send_last_c) state_d = RECV;
        end
      end
      RECV: begin
        if (s_valid && s_ready) begin
          recv_xfer_c = 1'b1;
          if (recv_last_c) state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered status/handshake outputs, outgoing word and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      m_valid  <= 1'b0;
      s_ready  <= 1'b0;
      m_data   <= '0;
      send_cnt <= '0;
      recv_cnt <= '0;
    end else begin
      busy    <= (state_d != IDLE);
      done    <= (state_d == FIN);
      m_valid <= (state_d == SEND);
      s_ready <= (state_d == RECV);
      if (start_acc_c) begin
        send_cnt <= '0;
        recv_cnt <= '0;
        // a same-cycle write to word 0 must reach the first transfer
        if (wr_acc_c && wr_addr == '0) m_data <= wr_data;
        else                            m_data <= inbuf[0];
      end
      if (send_xfer_c) begin
        send_cnt <= send_nxt_c;
        if (!send_last_c) m_data <= inbuf[send_nxt_c];
      end
      if (recv_xfer_c) recv_cnt <= recv_cnt + LM'(1);
    end
  end

  // Input and result buffer writes; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_acc_c) inbuf[wr_addr] <= wr_data;
    if (recv_xfer_c && !reset) resbuf[recv_cnt] <= s_data;
  end

  // Registered result read port; out-of-range addresses read as zero
  always_ff @(posedge clk) begin
    if (reset)                    rd_data <= '0;
    else if (32'(rd_addr) < M)    rd_data <= resbuf[rd_addr];
    else                          rd_data <= '0;
  end

`ifdef ARGMAX_EN
  // Running signed argmax; strict compare keeps the lowest index on ties
  always_ff @(posedge clk) begin
    if (reset) begin
      argmax_idx <= '0;
      argmax_val <= '0;
    end else if (recv_xfer_c) begin
      if (recv_cnt == '0) begin
        argmax_idx <= '0;
        argmax_val <= s_data;
      end else if ($signed(s_data) > $signed(argmax_val)) begin
        argmax_idx <= recv_cnt;
        argmax_val <= s_data;
      end
    end
  end
`else
  assign argmax_idx = '0;
  assign argmax_val = '0;
`endif

endmodule

// File: tb/tb_layer_stream_host.sv
// Directed bench for layer_stream_host (N=12, M=16, T=20).
module tb_layer_stream_host;

  localparam int unsigned N = 12;
  localparam int unsigned M = 16;
  localparam int unsigned T = 20;

  logic         clk;
  logic         reset;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [T-1:0] wr_data;
  logic         start;
  logic         busy;
  logic         done;
  logic         m_valid;
  logic         m_ready;
  logic [T-1:0] m_data;
  logic         s_valid;
  logic         s_ready;
  logic [T-1:0] s_data;
  logic [3:0]   rd_addr;
  logic [T-1:0] rd_data;
  logic [3:0]   argmax_idx;
  logic [T-1:0] argmax_val;

  int errors = 0;
  int checks = 0;
  logic [T-1:0] res [16];

  layer_stream_host dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .argmax_idx(argmax_idx), .argmax_val(argmax_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input bit w0, input logic [T-1:0] d);
    start   = 1'b1;
    wr_en   = w0;
    wr_addr = 4'd0;
    wr_data = d;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Drives m_ready from pat (bit per cycle), checks each offered word
  task automatic send_phase(input logic [31:0] pat, input int exp_cycles, input bit poke,
                            input logic [T-1:0] first, input logic [T-1:0] prev0);
    int sent;
    int c;
    logic [T-1:0] exp;
    sent = 0;
    c = 0;
    while (sent < N && c < 40) begin
      m_ready = (c < 32) ? pat[c] : 1'b1;
      wr_en   = poke && (c == 1);
      wr_addr = 4'd0;
      wr_data = 20'hFFFFF;
      s_valid = poke && (c == 1);
      s_data  = 20'd55;
      exp = (sent == 0) ? first : T'(sent + 1);
      check("m_valid_send", 32'(m_valid), 32'd1);
      check("m_data", 32'(m_data), 32'(exp));
      check("s_ready_send", 32'(s_ready), 32'd0);
      if (m_ready) sent++;
      tick();
      c++;
    end
    m_ready = 1'b0;
    wr_en   = 1'b0;
    s_valid = 1'b0;
    check("send_count", 32'(sent), 32'(N));
    check("send_cycles", 32'(c), 32'(exp_cycles));
    check("m_valid_off", 32'(m_valid), 32'd0);
    check("s_ready_recv", 32'(s_ready), 32'd1);
    check("resbuf0_untouched", 32'(rd_data), 32'(prev0));
  endtask

  // Returns res[] at full rate, checks done/busy/argmax and reads back resbuf
  task automatic recv_phase(input bit poke_start, input logic [3:0] ai, input logic [T-1:0] av);
    logic [3:0]   ei;
    logic [T-1:0] ev;
`ifdef ARGMAX_EN
    ei = ai;
    ev = av;
`else
    ei = 4'd0;
    ev = '0;
`endif
    for (int j = 0; j < 16; j++) begin
      s_valid = 1'b1;
      s_data  = res[j];
      start   = poke_start && (j == 3);
      check("s_ready_recv_loop", 32'(s_ready), 32'd1);
      check("done_early", 32'(done), 32'd0);
      tick();
    end
    s_valid = 1'b0;
    start   = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("busy_fin", 32'(busy), 32'd1);
    check("argmax_idx", 32'(argmax_idx), 32'(ei));
    check("argmax_val", 32'(argmax_val), 32'(ev));
    tick();
    check("done_clear", 32'(done), 32'd0);
    check("busy_clear", 32'(busy), 32'd0);
    tick();
    check("done_single", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("argmax_idx_hold", 32'(argmax_idx), 32'(ei));
    for (int j = 0; j < 16; j++) begin
      rd_addr = 4'(j);
      tick();
      check("rd_data", 32'(rd_data), 32'(res[j]));
    end
    rd_addr = 4'd0;
    tick();
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    m_ready = 1'b0; s_valid = 1'b0; s_data = '0; rd_addr = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_argmax_idx", 32'(argmax_idx), 32'd0);
    check("rst_argmax_val", 32'(argmax_val), 32'd0);
    reset = 1'b0;
    tick();

    // load inbuf[i] = i+1
    for (int i = 0; i < 12; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = T'(i + 1);
      tick();
    end
    wr_en = 1'b0;

    // run A: full rate, results 100+j
    for (int j = 0; j < 16; j++) res[j] = T'(100 + j);
    do_start(1'b0, '0);
    send_phase(32'hFFFF_FFFF, 12, 1'b0, 20'd1, 20'd0);
    recv_phase(1'b0, 4'd15, 20'd115);

    // run B: stall on word 3, write and s_valid during SEND, start during RECV
    res[0] = 20'd0; res[1] = -20'sd5; res[2] = 20'd7; res[3] = 20'd3; res[4] = 20'd7;
    for (int j = 5; j < 15; j++) res[j] = 20'd1;
    res[15] = 20'hFFFFF;
    do_start(1'b0, '0);
    send_phase(32'hFFFF_FFF3, 14, 1'b1, 20'd1, 20'd100);
    recv_phase(1'b1, 4'd2, 20'd7);

    // run C: all results -20
    for (int j = 0; j < 16; j++) res[j] = 20'hFFFEC;
    do_start(1'b0, '0);
    send_phase(32'hFFFF_FFFF, 12, 1'b0, 20'd1, 20'd0);
    recv_phase(1'b0, 4'd0, 20'hFFFEC);

    // reset after 5 sent words, with start held too
    do_start(1'b0, '0);
    m_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("pre_rst_m_data", 32'(m_data), 32'(k + 1));
      tick();
    end
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    m_ready = 1'b0;
    check("abort_m_valid", 32'(m_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_m_data", 32'(m_data), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
    end
    for (int j = 0; j < 16; j++) res[j] = T'(100 + j);
    do_start(1'b0, '0);
    send_phase(32'hFFFF_FFFF, 12, 1'b0, 20'd1, 20'hFFFEC);
    recv_phase(1'b0, 4'd15, 20'd115);

    // start and write to word 0 in the same cycle
    do_start(1'b1, 20'd77);
    send_phase(32'hFFFF_FFFF, 12, 1'b0, 20'd77, 20'd100);
    recv_phase(1'b0, 4'd15, 20'd115);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
